eth_rx_frame_writer: RTL and testbench
======================================

// Module: eth_rx_frame_writer
// PURPOSE
//  Sits directly downstream of dibits_to_bytes on the RMII receive path. Hunts preamble/SFD, streams frame
//  bytes (dest MAC through FCS) into packet_buffer_ram via its write port, checks CRC-32 FCS and length,
//  then reports per-frame status. Bad frames are rolled back so the buffer only advances on good frames.
// PARAMETERS
//  RAM_SIZE       PACKET_BUFFER_SIZE  depth of packet buffer; write_addr wraps modulo RAM_SIZE
//  MIN_FRAME_LEN  64                  min bytes after SFD incl. FCS; shorter -> runt error
//  MAX_FRAME_LEN  1518                max bytes after SFD incl. FCS; longer -> drop
//  MY_MAC         48'h02_00_00_00_00_01  accepted unicast dest (only with RX_MAC_FILTER_EN)
// PORTS
//  clk               in   1   system clock (50 MHz)
//  reset             in   1   synchronous, active-high
//  inclk             in   1   byte strobe from dibits_to_bytes outclk, 1 cycle per byte
//  in                in   8   byte from dibits_to_bytes out
//  done_in           in   1   end-of-carrier pulse from dibits_to_bytes done_out
//  write_enable      out  1   packet buffer write strobe
//  write_addr        out  clog2(RAM_SIZE)  packet buffer write address
//  write_val         out  8   packet buffer write data
//  frame_done        out  1   1-cycle pulse: frame finished (good or bad)
//  frame_ok          out  1   valid with frame_done: FCS residue ok, length in range, (filter pass)
//  frame_start_addr  out  clog2(RAM_SIZE)  buffer address of first dest-MAC byte; valid with frame_done
//  frame_len         out  11  bytes after SFD incl. FCS; saturates at 2047; valid with frame_done
//  busy              out  1   high in any state but IDLE
// BEHAVIOUR
//  Reset: all outputs 0; write pointer = 0; state IDLE; CRC reg = 32'hFFFFFFFF.
//  FSM: IDLE -inclk&in==8'h55-> PREAMBLE; IDLE -inclk&other byte-> DROP.
//   PREAMBLE: 8'h55 stays; 8'hD5 -> DATA (CRC reset, frame_start_addr latched = wr_ptr); other -> DROP.
//   DATA: each inclk byte written, CRC updated, count++; count would exceed MAX_FRAME_LEN -> DROP.
//   DROP: consumes bytes, no writes, until done_in.
//   done_in in PREAMBLE/DATA/DROP -> COMMIT; done_in in IDLE ignored.
//   COMMIT: one cycle, evaluates status, pulses frame_done, -> IDLE. inclk in COMMIT is ignored.
//  Write timing: byte sampled on inclk at edge N -> write_enable=1, write_addr=wr_ptr, write_val=byte
//   during cycle N+1; wr_ptr increments, wrapping RAM_SIZE-1 -> 0.
//  inclk and done_in same cycle: byte is processed first, then frame closes.
//  frame_done asserted cycle N+2 where done_in sampled at edge N (COMMIT sees final CRC).
//  CRC: reflected CRC-32, poly 32'hEDB88320, init all-ones, LSB-first per byte, over all DATA bytes
//   incl. FCS; good iff final reg == 32'hDEBB20E3.
//  frame_ok = came from DATA & residue ok & MIN_FRAME_LEN <= len <= MAX_FRAME_LEN (& filter pass).
//  frame_ok=0: wr_ptr restored to frame_start_addr (next frame overwrites). frame_ok=1: wr_ptr kept.
//  Frame closed from DROP/PREAMBLE: frame_done pulses, frame_ok=0, frame_len = bytes counted (0 if none).
//  No backpressure: reader overrun is out of scope; consumer must drain before wrap.
//  reset mid-frame: immediate IDLE, pending frame discarded, no frame_done, wr_ptr=0.
// CONFIGURATION
//  RX_MAC_FILTER_EN defined: first 6 DATA bytes compared to MY_MAC (first byte = MSB) and
//   48'hFFFF_FFFF_FFFF; if neither matches after byte 6, -> DROP (bytes already written are rolled back).
//  Undefined: all destinations accepted; no compare logic synthesized.
// STRUCTURE
//  params.vh: PACKET_BUFFER_SIZE, BYTE_LEN, clog2, new ETH_PREAMBLE_BYTE=8'h55, ETH_SFD_BYTE=8'hD5,
//   CRC32_POLY_REFL=32'hEDB88320, CRC32_RESIDUE=32'hDEBB20E3; FSM state localparams local to this file.
//  Sub-module crc32_bytewise (clk, reset, clear, inclk, in[7:0], out[31:0]): 1-byte/cycle combinational
//   update registered; reused later by the TX path.
// TESTING
//  1 Good frame: 7x55,D5, 60 bytes 00..3B, correct FCS, done_in -> 64 writes addr 0..63 in order,
//    frame_done once, frame_ok=1, frame_start_addr=0, frame_len=64.
//  2 Same frame, last FCS byte XOR 8'h01 -> 64 writes, frame_ok=0; next good frame starts at addr 0.
//  3 Runt: 40 data bytes + valid FCS -> frame_ok=0, frame_len=44; wr_ptr rolled back to 0.
//  4 Wrap: preload wr_ptr at RAM_SIZE-10 via prior good frames; good 64-byte frame -> addresses
//    RAM_SIZE-10..RAM_SIZE-1 then 0..53, frame_ok=1.
//  5 Bad preamble (55,55,A3,...) -> no writes, frame_done with frame_ok=0, frame_len=0; reset asserted
//    mid-DATA of next frame -> outputs 0, no frame_done, following frame written at addr 0.
//  6 RX_MAC_FILTER_EN: dest FF..FF -> ok; dest MY_MAC -> ok; dest 02:00:00:00:00:02 -> frame_ok=0,
//    wr_ptr unchanged. Without macro, third case -> frame_ok=1.

Source files
------------

// File: rtl/eth_rx_frame_writer_pkg.sv
// Shared constants, FSM state type and byte-wise CRC-32 helper for the RMII receive frame writer.
package eth_rx_frame_writer_pkg;

    localparam int unsigned PACKET_BUFFER_SIZE = 2048;
    localparam int unsigned BYTE_LEN           = 8;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
    localparam logic [47:0] ETH_BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP,
        ST_COMMIT
    } rx_state_t;

    // Reflected CRC-32 step over one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int unsigned i = 0; i < BYTE_LEN; i++) begin
            if (c[0] ^ data[i])
                c = (c >> 1) ^ CRC32_POLY_REFL;
            else
                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_frame_writer_crc32.sv
// Registered CRC-32 accumulator, one byte per strobe; shared by the RX and TX paths.
module crc32_bytewise
    import eth_rx_frame_writer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        inclk,
    input  logic [7:0]  in,
    output logic [31:0] out
);

    always_ff @(posedge clk) begin
        if (reset || clear)
            out <= '1;
        else if (inclk)
            out <= crc32_byte(out, in);
    end

endmodule

// File: rtl/eth_rx_frame_writer.sv
// RMII receive frame writer: preamble/SFD hunt, packet buffer writes, FCS/length check, rollback of bad frames.
// Optional destination MAC filter enabled by defining RX_MAC_FILTER_EN.
module eth_rx_frame_writer
    import eth_rx_frame_writer_pkg::*;
#(
    parameter int unsigned RAM_SIZE      = PACKET_BUFFER_SIZE,
    parameter int unsigned MIN_FRAME_LEN = 64,
    parameter int unsigned MAX_FRAME_LEN = 1518,
    parameter logic [47:0] MY_MAC        = 48'h02_00_00_00_00_01
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inclk,
    input  logic [7:0]                  in,
    input  logic                        done_in,
    output logic                        write_enable,
    output logic [$clog2(RAM_SIZE)-1:0] write_addr,
    output logic [7:0]                  write_val,
    output logic                        frame_done,
    output logic                        frame_ok,
    output logic [$clog2(RAM_SIZE)-1:0] frame_start_addr,
    output logic [10:0]                 frame_len,
    output logic                        busy
);

    localparam int unsigned AW = $clog2(RAM_SIZE);
    localparam logic [10:0] MIN_LEN11 = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] MAX_LEN11 = 11'(MAX_FRAME_LEN);

    rx_state_t state, state_byte, state_next;

    logic [AW-1:0] wr_ptr, wr_ptr_inc, start_ptr;
    logic [10:0]   count;
    logic          in_frame;
    logic          from_data;
    logic          take_byte;
    logic          sfd_seen;
    logic          closing;
    logic          count_full;
    logic          mac_reject;
    logic          frame_good;
    logic [31:0]   crc_val;

    crc32_bytewise u_crc (
        .clk   (clk),
        .reset (reset),
        .clear (sfd_seen),
        .inclk (take_byte),
        .in    (in),
        .out   (crc_val)
    );

`ifdef RX_MAC_FILTER_EN
    logic       ucast_match, bcast_match;
    logic       in_dest, ucast_hit, bcast_hit;
    logic [7:0] my_byte;

    // Destination bytes arrive MSB first; byte k of MY_MAC sits at bits [47-8k -: 8].
    always_comb begin
        in_dest    = (count < 11'd6);
        my_byte    = 8'(MY_MAC >> {3'd5 - count[2:0], 3'b000});
        ucast_hit  = ucast_match && (in == my_byte);
        bcast_hit  = bcast_match && (in == ETH_BCAST_MAC[7:0]);
        mac_reject = (count == 11'd5) && !ucast_hit && !bcast_hit;
    end

    always_ff @(posedge clk) begin
        if (reset || sfd_seen) begin
            ucast_match <= 1'b1;
            bcast_match <= 1'b1;
        end else if (take_byte && in_dest) begin
            ucast_match <= ucast_hit;
            bcast_match <= bcast_hit;
        end
    end
`else
    logic unused_mac;
    assign unused_mac = ^MY_MAC;
    assign mac_reject = 1'b0;
`endif

    assign count_full = (count >= MAX_LEN11);
    assign wr_ptr_inc = (wr_ptr == AW'(RAM_SIZE - 1)) ? '0 : wr_ptr + AW'(1);
    assign frame_good = from_data && (crc_val == CRC32_RESIDUE) &&
                        (count >= MIN_LEN11) && (count <= MAX_LEN11);
    assign busy       = (state != ST_IDLE);

    // The incoming byte is resolved first (state_byte); done_in then overrides to COMMIT.
    always_comb begin
        state_byte = state;
        take_byte  = 1'b0;
        sfd_seen   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (inclk)
                    state_byte = (in == ETH_PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
            end
            ST_PREAMBLE: begin
                if (inclk) begin
                    if (in == ETH_SFD_BYTE) begin
                        state_byte = ST_DATA;
                        sfd_seen   = 1'b1;
                    end else if (in != ETH_PREAMBLE_BYTE) begin
                        state_byte = ST_DROP;
                    end
                end
            end
            ST_DATA: begin
                if (inclk) begin
                    if (count_full) begin
                        state_byte = ST_DROP;
                    end else begin
                        take_byte = 1'b1;
                        if (mac_reject)
                            state_byte = ST_DROP;
                    end
                end
            end
            ST_COMMIT: state_byte = ST_IDLE;
            default: ;
        endcase
        closing    = done_in && (state == ST_PREAMBLE || state == ST_DATA || state == ST_DROP);
        state_next = closing ? ST_COMMIT : state_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            wr_ptr           <= '0;
            start_ptr        <= '0;
            count            <= '0;
            in_frame         <= 1'b0;
            from_data        <= 1'b0;
            write_enable     <= 1'b0;
            write_addr       <= '0;
            write_val        <= '0;
            frame_done       <= 1'b0;
            frame_ok         <= 1'b0;
            frame_start_addr <= '0;
            frame_len        <= '0;
        end else begin
            state        <= state_next;
            write_enable <= take_byte;
            frame_done   <= 1'b0;

            if (take_byte) begin
                write_addr <= wr_ptr;
                write_val  <= in;
                wr_ptr     <= wr_ptr_inc;
            end

            // No writes happen outside DATA, so tracking wr_ptr while idle equals latching it at SFD.
            if (state == ST_IDLE)
                start_ptr <= wr_ptr;

            if (state == ST_IDLE) begin
                count    <= '0;
                in_frame <= 1'b0;
            end else if (sfd_seen) begin
                count    <= '0;
                in_frame <= 1'b1;
            end else if (inclk && in_frame && (state == ST_DATA || state == ST_DROP) &&
                         count != '1) begin
                count <= count + 11'd1;
            end

            if (closing)
                from_data <= (state_byte == ST_DATA);

            if (state == ST_COMMIT) begin
                frame_done       <= 1'b1;
                frame_ok         <= frame_good;
                frame_start_addr <= start_ptr;
                frame_len        <= count;
                if (!frame_good)
                    wr_ptr <= start_ptr;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// Self-checking bench for eth_rx_frame_writer: vector table, corner-case sequences and random frames vs a frame-level model.
module tb_eth_rx_frame_writer;

    localparam int unsigned RAM  = 256;
    localparam int unsigned MINL = 64;
    localparam int unsigned MAXL = 1518;
    localparam logic [47:0] MYMAC = 48'h02_00_00_00_00_01;
`ifdef RX_MAC_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [7:0] addr; logic [7:0] val; } wr_t;
    typedef wr_t wq_t[$];
    typedef struct { bit ok; int len; int start; } fd_t;
    typedef struct {
        string       name;
        int          npre;
        int          ndata;
        bit          use_dest;
        logic [47:0] dest;
        int          mode;     // 0 good, 1 corrupt FCS, 2 bad preamble, 3 junk first byte
        bit          exp_ok;
        int          exp_len;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, inclk, done_in;
    logic [7:0] in_byte;
    logic       write_enable, frame_done, frame_ok, busy;
    logic [7:0] write_addr, frame_start_addr, write_val;
    logic [10:0] frame_len;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;
    logic [31:0] crc_tab[256];
    wr_t wq[$];
    fd_t fq[$];
    vec_t vecs[$];

    eth_rx_frame_writer #(
        .RAM_SIZE      (RAM),
        .MIN_FRAME_LEN (MINL),
        .MAX_FRAME_LEN (MAXL),
        .MY_MAC        (MYMAC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .inclk            (inclk),
        .in               (in_byte),
        .done_in          (done_in),
        .write_enable     (write_enable),
        .write_addr       (write_addr),
        .write_val        (write_val),
        .frame_done       (frame_done),
        .frame_ok         (frame_ok),
        .frame_start_addr (frame_start_addr),
        .frame_len        (frame_len),
        .busy             (busy)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (write_enable) wq.push_back('{write_addr, write_val});
            if (frame_done)   fq.push_back('{frame_ok, int'(frame_len), int'(frame_start_addr)});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fcs_of(input bq_t d, input int n);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < n; i++) c = (c >> 8) ^ crc_tab[c[7:0] ^ d[i]];
        return ~c;
    endfunction

    function automatic bq_t build(input int npre, input int ndata, input bit use_dest,
                                  input logic [47:0] dest, input bit corrupt);
        bq_t b, d;
        logic [31:0] f;
        for (int i = 0; i < npre; i++) b.push_back(8'h55);
        b.push_back(8'hD5);
        for (int i = 0; i < ndata; i++) d.push_back(8'(i));
        if (use_dest)
            for (int i = 0; i < 6 && i < ndata; i++) d[i] = dest[47-8*i -: 8];
        f = fcs_of(d, ndata);
        d.push_back(f[7:0]);
        d.push_back(f[15:8]);
        d.push_back(f[23:16]);
        d.push_back(f[31:24]);
        if (corrupt) d[d.size()-1] = d[d.size()-1] ^ 8'h01;
        return {b, d};
    endfunction

    // Frame-level reference: parse preamble, then derive writes, length and status from the byte list.
    task automatic model_frame(input bq_t b, input int ptr, output wq_t ew, output bit eok, output int elen);
        int i, s, nw;
        bit rej, fcs_good;
        bq_t d;
        logic [47:0] dst;
        ew = {};
        eok = 1'b0;
        elen = 0;
        i = 0;
        while (i < b.size() && b[i] == 8'h55) i++;
        if (i == 0 || i >= b.size() || b[i] != 8'hD5) return;
        d = b[i+1:$];
        s = d.size();
        elen = (s > 2047) ? 2047 : s;
        nw = (s > int'(MAXL)) ? int'(MAXL) : s;
        rej = 1'b0;
        if (FILTER && s >= 6) begin
            dst = {d[0], d[1], d[2], d[3], d[4], d[5]};
            rej = (dst != MYMAC) && (dst != 48'hFFFF_FFFF_FFFF);
            if (rej) nw = 6;
        end
        fcs_good = (s >= 4) && (fcs_of(d, s - 4) == {d[s-1], d[s-2], d[s-3], d[s-4]});
        eok = !rej && (s >= int'(MINL)) && (s <= int'(MAXL)) && fcs_good;
        for (int k = 0; k < nw; k++) ew.push_back('{8'((ptr + k) % RAM), d[k]});
    endtask

    task automatic send(input bq_t b, input bit done_with_last);
        for (int i = 0; i < b.size(); i++) begin
            inclk   = 1'b1;
            in_byte = b[i];
            if (done_with_last && i == b.size() - 1) done_in = 1'b1;
            @(posedge clk); #1;
            inclk   = 1'b0;
            done_in = 1'b0;
            in_byte = 8'($urandom);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        if (!done_with_last) begin
            done_in = 1'b1;
            @(posedge clk); #1;
            done_in = 1'b0;
        end
    endtask

    task automatic run_frame(input string name, input bq_t b, input bit has_exp,
                             input bit t_ok, input int t_len);
        wq_t ew;
        bit eok;
        int elen, errs, waited;
        model_frame(b, ptr_m, ew, eok, elen);
        wq.delete();
        fq.delete();
        send(b, 1'($urandom_range(0, 1)));
        waited = 0;
        while (fq.size() == 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        check({name, "_done_count"}, fq.size(), 1);
        if (fq.size() > 0) begin
            check({name, "_ok"}, fq[0].ok, eok);
            check({name, "_len"}, fq[0].len, elen);
            check({name, "_start"}, fq[0].start, ptr_m);
            if (has_exp) begin
                check({name, "_ok_tbl"}, fq[0].ok, t_ok);
                check({name, "_len_tbl"}, fq[0].len, t_len);
            end
        end
        check({name, "_wr_count"}, wq.size(), ew.size());
        errs = 0;
        for (int k = 0; k < wq.size() && k < ew.size(); k++)
            if (wq[k].addr != ew[k].addr || wq[k].val != ew[k].val) errs++;
        check({name, "_wr_mismatches"}, errs, 0);
        if (eok) ptr_m = (ptr_m + elen) % RAM;
    endtask

    initial begin
        bq_t b;
        int delta, n;
        logic [47:0] dest;

        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end

        vecs.push_back('{"good64",   7, 60,   1'b0, 48'h0,             0, !FILTER, 64});
        vecs.push_back('{"bad_fcs",  7, 60,   1'b0, 48'h0,             1, 1'b0,    64});
        vecs.push_back('{"runt44",   7, 40,   1'b0, 48'h0,             0, 1'b0,    44});
        vecs.push_back('{"len63",    7, 59,   1'b1, 48'hFFFFFFFFFFFF, 0, 1'b0,    63});
        vecs.push_back('{"bad_pre",  7, 60,   1'b0, 48'h0,             2, 1'b0,    0});
        vecs.push_back('{"junk_1st", 7, 60,   1'b0, 48'h0,             3, 1'b0,    0});
        vecs.push_back('{"bcast",    7, 60,   1'b1, 48'hFFFFFFFFFFFF, 0, 1'b1,    64});
        vecs.push_back('{"my_mac",   7, 60,   1'b1, MYMAC,            0, 1'b1,    64});
        vecs.push_back('{"other",    7, 60,   1'b1, 48'h020000000002, 0, !FILTER, 64});
        vecs.push_back('{"max1518",  7, 1514, 1'b1, 48'hFFFFFFFFFFFF, 0, 1'b1,    1518});
        vecs.push_back('{"over1519", 7, 1515, 1'b1, 48'hFFFFFFFFFFFF, 0, 1'b0,    1519});
        vecs.push_back('{"pre1",     1, 70,   1'b1, 48'hFFFFFFFFFFFF, 0, 1'b1,    74});

        reset   = 1'b1;
        inclk   = 1'b0;
        done_in = 1'b0;
        in_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_write_enable", write_enable, 0);
        check("rst_write_addr", write_addr, 0);
        check("rst_write_val", write_val, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_start_addr", frame_start_addr, 0);
        check("rst_frame_len", frame_len, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < vecs.size(); v++) begin
            b = build(vecs[v].npre, vecs[v].ndata, vecs[v].use_dest, vecs[v].dest, vecs[v].mode == 1);
            if (vecs[v].mode == 2) b[2] = 8'hA3;
            if (vecs[v].mode == 3) b[0] = 8'h3C;
            run_frame(vecs[v].name, b, 1'b1, vecs[v].exp_ok, vecs[v].exp_len);
        end

        // done_in while idle must not produce a frame.
        fq.delete();
        done_in = 1'b1;
        @(posedge clk); #1;
        done_in = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_done_ignored", fq.size(), 0);
        check("idle_busy", busy, 0);

        // Advance the write pointer to RAM-10 with one good frame, then straddle the wrap.
        delta = (int'(RAM) - 10 - ptr_m + int'(RAM)) % int'(RAM);
        if (delta != 0) begin
            n = (delta < 64) ? delta + int'(RAM) : delta;
            run_frame("wrap_fill", build(7, n - 4, 1'b1, 48'hFFFFFFFFFFFF, 1'b0), 1'b1, 1'b1, n);
        end
        run_frame("wrap", build(7, 60, 1'b1, 48'hFFFFFFFFFFFF, 1'b0), 1'b1, 1'b1, 64);
        if (wq.size() >= 64) begin
            check("wrap_first_addr", wq[0].addr, RAM - 10);
            check("wrap_last_before", wq[9].addr, RAM - 1);
            check("wrap_zero_addr", wq[10].addr, 0);
            check("wrap_last_addr", wq[63].addr, 53);
        end else begin
            check("wrap_write_count", wq.size(), 64);
        end

        // Reset in the middle of DATA: everything clears, no frame_done, pointer back to 0.
        fq.delete();
        b = build(7, 60, 1'b1, 48'hFFFFFFFFFFFF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            inclk   = 1'b1;
            in_byte = b[i];
            @(posedge clk); #1;
            inclk = 1'b0;
        end
        check("mid_busy_before_rst", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_write_enable", write_enable, 0);
        check("midrst_write_addr", write_addr, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_len", frame_len, 0);
        reset = 1'b0;
        ptr_m = 0;
        repeat (6) @(negedge clk);
        check("midrst_no_done", fq.size(), 0);
        run_frame("after_rst", build(7, 60, 1'b1, 48'hFFFFFFFFFFFF, 1'b0), 1'b1, 1'b1, 64);

        for (int r = 0; r < 25; r++) begin
            case ($urandom_range(0, 3))
                0: dest = 48'hFFFF_FFFF_FFFF;
                1: dest = MYMAC;
                default: dest = {16'($urandom), 32'($urandom)};
            endcase
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 59)) : int'($urandom_range(60, 140));
            b = build(int'($urandom_range(1, 7)), n, $urandom_range(0, 3) != 0, dest,
                      $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) b[0] = 8'h17;
            run_frame("random", b, 1'b0, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
